// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

   localparam int unsigned XLEN = 32;

   // Canonical NOP (addi x0, x0, 0), shown on id_inst out of reset
   localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

   // Next-PC select driven by execute; PC_ALU marks a taken branch/jump
   typedef enum logic {
      PC_PC4 = 1'b0,
      PC_ALU = 1'b1
   } pc_sel_e;

   // One fetch-queue slot: allocated at request, filled by the response
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic            filled;
   } ifq_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// In-order fetch queue: slots allocated at request, filled by responses, drained by decode.
module ifetch_queue
   import ifetch_pkg::*;
#(
   parameter int unsigned     QDEPTH   = 2,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   localparam int unsigned    PW       = $clog2(QDEPTH),
   localparam int unsigned    CW       = PW + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            alloc,
   input  logic [XLEN-1:0] alloc_pc,
   input  logic            fill,
   input  logic [XLEN-1:0] fill_data,
   input  logic            deq,
   output logic [CW-1:0]   free_slots,
   output logic [CW-1:0]   unfilled,
   output logic            head_valid,
   output logic [XLEN-1:0] head_pc,
   output logic [XLEN-1:0] head_inst
);

   ifq_entry_t    ent_q [QDEPTH];
   ifq_entry_t    ent_d [QDEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] fill_q, fill_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] ucnt_q, ucnt_d;

   // A slot being dequeued this cycle can be re-allocated in the same cycle
   assign free_slots = CW'(QDEPTH) - cnt_q + CW'(deq);
   assign unfilled   = ucnt_q;
   assign head_valid = ent_q[head_q].filled;
   assign head_pc    = ent_q[head_q].pc;
   assign head_inst  = ent_q[head_q].inst;

   // Next-state for slots and pointers; flush empties the queue outright
   always_comb begin
      ent_d  = ent_q;
      head_d = head_q;
      fill_d = fill_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      ucnt_d = ucnt_q;
      if (flush) begin
         head_d = '0;
         fill_d = '0;
         tail_d = '0;
         cnt_d  = '0;
         ucnt_d = '0;
         for (int unsigned i = 0; i < QDEPTH; i++) begin
            ent_d[i].filled = 1'b0;
         end
      end else begin
         if (deq) begin
            ent_d[head_q].filled = 1'b0;
            head_d               = head_q + PW'(1);
         end
         if (alloc) begin
            ent_d[tail_q].pc     = alloc_pc;
            ent_d[tail_q].filled = 1'b0;
            tail_d               = tail_q + PW'(1);
         end
         if (fill) begin
            ent_d[fill_q].inst   = fill_data;
            ent_d[fill_q].filled = 1'b1;
            fill_d               = fill_q + PW'(1);
         end
         cnt_d  = cnt_q + CW'(alloc) - CW'(deq);
         ucnt_d = ucnt_q + CW'(alloc) - CW'(fill);
      end
   end

   // Queue state register; reset leaves a NOP at RESET_PC in the head slot
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < QDEPTH; i++) begin
            ent_q[i] <= '{pc: RESET_PC, inst: INST_NOP, filled: 1'b0};
         end
         head_q <= '0;
         fill_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         ucnt_q <= '0;
      end else begin
         ent_q  <= ent_d;
         head_q <= head_d;
         fill_q <= fill_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         ucnt_q <= ucnt_d;
      end
   end

endmodule

// File: rtl/ifetch.sv
// RV32I fetch stage: fetch PC, memory request channel, redirect and stale-response dropping.
module ifetch
   import ifetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned     QDEPTH   = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_inst,
   output logic [XLEN-1:0] id_pc
);

   localparam int unsigned CW = $clog2(QDEPTH) + 1;
   localparam int unsigned SW = CW + 1;
   // drop_cnt can only hold this many in-flight responses
   localparam logic [SW-1:0] OUTSTANDING_MAX = SW'((1 << CW) - 1);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]   free_slots;
   logic [CW-1:0]   unfilled;
   logic [SW-1:0]   outstanding;
   logic            req_fire;
   logic            fill;
   logic            deq;
   logic            resp_orphan;
   logic            unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Stale (dropped) plus live in-flight responses
   assign outstanding    = SW'(drop_cnt_q) + SW'(unfilled);
   assign imem_req_valid = !rst && !redirect_valid && (free_slots != '0)
                           && (outstanding < OUTSTANDING_MAX);
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign deq            = id_valid && id_ready;
   assign resp_orphan    = imem_resp_valid && (drop_cnt_q == '0) && (unfilled == '0);

   // Fetch PC / drop counter next-state; redirect overrides everything
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      drop_cnt_d = drop_cnt_q;
      fill       = 1'b0;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
         // every in-flight response except one arriving now must be dropped
         if (imem_resp_valid && (outstanding != '0)) begin
            drop_cnt_d = CW'(outstanding - SW'(1));
         end else begin
            drop_cnt_d = CW'(outstanding);
         end
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (imem_resp_valid) begin
            if (drop_cnt_q != '0) begin
               drop_cnt_d = drop_cnt_q - CW'(1);
            end else begin
               fill = (unfilled != '0);
            end
         end
      end
   end

   // Fetch PC and drop counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         drop_cnt_q <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   ifetch_queue #(
      .QDEPTH   (QDEPTH),
      .RESET_PC (RESET_PC)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_valid),
      .alloc      (req_fire),
      .alloc_pc   (fetch_pc_q),
      .fill       (fill),
      .fill_data  (imem_resp_data),
      .deq        (deq),
      .free_slots (free_slots),
      .unfilled   (unfilled),
      .head_valid (id_valid),
      .head_pc    (id_pc),
      .head_inst  (id_inst)
   );

   // A response with nothing outstanding is a memory protocol violation
   a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst) !resp_orphan)
      else $error("ifetch: imem response with no outstanding request");

endmodule

// File: tb/tb_ifetch.sv
// Directed vector bench for ifetch with an in-order, fixed-latency memory model.
module tb_ifetch;
   import ifetch_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_valid;
   logic        id_ready = 1'b1;
   logic [31:0] id_inst;
   logic [31:0] id_pc;

   int n_checks = 0;
   int n_errors = 0;
   int mem_lat  = 1;
   int cyc      = 0;

   ifetch #(.RESET_PC(RESET_PC), .QDEPTH(2)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .id_valid        (id_valid),
      .id_ready        (id_ready),
      .id_inst         (id_inst),
      .id_pc           (id_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // memory model: accepted requests answered in order after mem_lat cycles
   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;
   pend_t pend[$];

   always @(negedge clk) begin
      if (rst) pend.delete();
      else if (imem_req_valid && imem_req_ready) pend.push_back('{imem_req_addr, cyc + mem_lat});
   end

   always @(posedge clk) begin
      if (imem_resp_valid && pend.size() > 0) void'(pend.pop_front());
      cyc = cyc + 1;
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = inst_of(pend[0].addr);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = '0;
      end
   end

   typedef struct {
      string       tag;
      bit          rst;
      bit          rdy;
      bit          idr;
      bit          rdv;
      logic [31:0] rpc;
      int          lat;
      bit          rv_only;
      bit          e_rv;
      logic [31:0] e_addr;
      bit          e_iv;
      logic [31:0] e_pc;
      bit          e_nop;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input string tag, input bit r, input bit rdy, input bit idr,
                               input bit rdv, input logic [31:0] rpc, input int lat,
                               input bit rv_only, input bit e_rv, input logic [31:0] e_addr,
                               input bit e_iv, input logic [31:0] e_pc, input bit e_nop);
      vec_t v;
      v.tag = tag; v.rst = r; v.rdy = rdy; v.idr = idr; v.rdv = rdv; v.rpc = rpc;
      v.lat = lat; v.rv_only = rv_only; v.e_rv = e_rv; v.e_addr = e_addr;
      v.e_iv = e_iv; v.e_pc = e_pc; v.e_nop = e_nop;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      @(posedge clk);
      #1;
      rst            = v.rst;
      imem_req_ready = v.rdy;
      id_ready       = v.idr;
      redirect_valid = v.rdv;
      redirect_pc    = v.rpc;
      mem_lat        = v.lat;
      @(negedge clk);
      chk({v.tag, ".req_valid"}, 32'(imem_req_valid), 32'(v.e_rv));
      if (!v.rv_only) begin
         chk({v.tag, ".req_addr"}, imem_req_addr, v.e_addr);
         chk({v.tag, ".id_valid"}, 32'(id_valid), 32'(v.e_iv));
         if (v.e_iv) begin
            chk({v.tag, ".id_pc"}, id_pc, v.e_pc);
            chk({v.tag, ".id_inst"}, id_inst, inst_of(v.e_pc));
         end
         if (v.e_nop) begin
            chk({v.tag, ".id_inst_nop"}, id_inst, INST_NOP);
            chk({v.tag, ".id_pc_rst"}, id_pc, RESET_PC);
         end
      end
   endtask

   // two reset cycles: the first only checks the request is withdrawn
   task automatic add_reset(input string s, input int lat);
      tbl.push_back(mk({s, "_rst0"}, 1, 1, 1, 0, 0, lat, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk({s, "_rst1"}, 1, 1, 1, 0, 0, lat, 0, 0, RESET_PC, 0, 0, 1));
   endtask

   initial begin
      // A: streaming, latency 1, decode always ready
      add_reset("A", 1);
      tbl.push_back(mk("A2", 0, 1, 1, 0, 0, 1, 0, 1, 32'h0, 0, 0, 1));
      tbl.push_back(mk("A3", 0, 1, 1, 0, 0, 1, 0, 1, 32'h4, 0, 0, 0));
      for (int n = 4; n < 10; n++)
         tbl.push_back(mk($sformatf("A%0d", n), 0, 1, 1, 0, 0, 1, 0, 1,
                          32'(4 * (n - 2)), 1, 32'(4 * (n - 4)), 0));
      // B: decode stalled, queue fills, then drains in order
      add_reset("B", 1);
      tbl.push_back(mk("B0", 0, 1, 0, 0, 0, 1, 0, 1, 32'h0, 0, 0, 0));
      tbl.push_back(mk("B1", 0, 1, 0, 0, 0, 1, 0, 1, 32'h4, 0, 0, 0));
      tbl.push_back(mk("B2", 0, 1, 0, 0, 0, 1, 0, 0, 32'h8, 1, 32'h0, 0));
      tbl.push_back(mk("B3", 0, 1, 0, 0, 0, 1, 0, 0, 32'h8, 1, 32'h0, 0));
      tbl.push_back(mk("B4", 0, 1, 1, 0, 0, 1, 0, 1, 32'h8, 1, 32'h0, 0));
      tbl.push_back(mk("B5", 0, 1, 1, 0, 0, 1, 0, 1, 32'hC, 1, 32'h4, 0));
      tbl.push_back(mk("B6", 0, 1, 1, 0, 0, 1, 0, 1, 32'h10, 1, 32'h8, 0));
      // C: memory not ready for 3 cycles, address held
      add_reset("C", 1);
      tbl.push_back(mk("C0", 0, 1, 1, 0, 0, 1, 0, 1, 32'h0, 0, 0, 0));
      tbl.push_back(mk("C1", 0, 1, 1, 0, 0, 1, 0, 1, 32'h4, 0, 0, 0));
      tbl.push_back(mk("C2", 0, 0, 1, 0, 0, 1, 0, 1, 32'h8, 1, 32'h0, 0));
      tbl.push_back(mk("C3", 0, 0, 1, 0, 0, 1, 0, 1, 32'h8, 1, 32'h4, 0));
      tbl.push_back(mk("C4", 0, 0, 1, 0, 0, 1, 0, 1, 32'h8, 0, 0, 0));
      tbl.push_back(mk("C5", 0, 1, 1, 0, 0, 1, 0, 1, 32'h8, 0, 0, 0));
      tbl.push_back(mk("C6", 0, 1, 1, 0, 0, 1, 0, 1, 32'hC, 0, 0, 0));
      tbl.push_back(mk("C7", 0, 1, 1, 0, 0, 1, 0, 1, 32'h10, 1, 32'h8, 0));

      foreach (tbl[i]) run_vec(tbl[i]);

      // D: redirect with 2 outstanding (latency 3); both stale responses dropped
      run_vec(mk("D_rst0", 1, 1, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0));
      run_vec(mk("D_rst1", 1, 1, 1, 0, 0, 3, 0, 0, RESET_PC, 0, 0, 1));
      run_vec(mk("D0", 0, 1, 1, 0, 0, 3, 0, 1, 32'h0, 0, 0, 0));
      run_vec(mk("D1", 0, 1, 1, 0, 0, 3, 0, 1, 32'h4, 0, 0, 0));
      run_vec(mk("D2", 0, 1, 1, 1, 32'h103, 3, 0, 0, 32'h8, 0, 0, 0));
      run_vec(mk("D3", 0, 1, 1, 0, 0, 3, 0, 1, 32'h100, 0, 0, 0));
      run_vec(mk("D4", 0, 1, 1, 0, 0, 3, 0, 1, 32'h104, 0, 0, 0));
      run_vec(mk("D5", 0, 1, 1, 0, 0, 3, 0, 0, 32'h108, 0, 0, 0));
      run_vec(mk("D6", 0, 1, 1, 0, 0, 3, 0, 0, 32'h108, 0, 0, 0));
      run_vec(mk("D7", 0, 1, 1, 0, 0, 3, 0, 1, 32'h108, 1, 32'h100, 0));
      run_vec(mk("D8", 0, 1, 1, 0, 0, 3, 0, 1, 32'h10C, 1, 32'h104, 0));

      // E: redirect coincides with the only outstanding response
      run_vec(mk("E_rst0", 1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0));
      run_vec(mk("E_rst1", 1, 1, 1, 0, 0, 2, 0, 0, RESET_PC, 0, 0, 1));
      run_vec(mk("E0", 0, 1, 1, 0, 0, 2, 0, 1, 32'h0, 0, 0, 0));
      run_vec(mk("E1", 0, 0, 1, 0, 0, 2, 0, 1, 32'h4, 0, 0, 0));
      run_vec(mk("E2", 0, 0, 1, 1, 32'h200, 2, 0, 0, 32'h4, 0, 0, 0));
      run_vec(mk("E3", 0, 1, 1, 0, 0, 2, 0, 1, 32'h200, 0, 0, 0));
      run_vec(mk("E4", 0, 1, 1, 0, 0, 2, 0, 1, 32'h204, 0, 0, 0));
      run_vec(mk("E5", 0, 1, 1, 0, 0, 2, 0, 0, 32'h208, 0, 0, 0));
      run_vec(mk("E6", 0, 1, 1, 0, 0, 2, 0, 1, 32'h208, 1, 32'h200, 0));
      run_vec(mk("E7", 0, 1, 1, 0, 0, 2, 0, 1, 32'h20C, 1, 32'h204, 0));

      // F: reset with two filled slots
      run_vec(mk("F_rst0", 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      run_vec(mk("F_rst1", 1, 1, 0, 0, 0, 1, 0, 0, RESET_PC, 0, 0, 1));
      run_vec(mk("F0", 0, 1, 0, 0, 0, 1, 0, 1, 32'h0, 0, 0, 0));
      run_vec(mk("F1", 0, 1, 0, 0, 0, 1, 0, 1, 32'h4, 0, 0, 0));
      run_vec(mk("F2", 0, 1, 0, 0, 0, 1, 0, 0, 32'h8, 1, 32'h0, 0));
      run_vec(mk("F3", 0, 1, 0, 0, 0, 1, 0, 0, 32'h8, 1, 32'h0, 0));
      run_vec(mk("F4", 1, 1, 0, 0, 0, 1, 0, 0, 32'h8, 1, 32'h0, 0));
      run_vec(mk("F5", 0, 1, 0, 0, 0, 1, 0, 1, RESET_PC, 0, 0, 1));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
